epw_result_scoreboard: RTL

- Parametrised, synthesizable result checker that pairs reference-model and DUV completions by result tag.
- Supports out-of-order completion across tags.
- Flags mismatches, duplicate completions and timeouts, and keeps saturating pass/fail counters.
- Sits beside the processor DUV and reference model; successor to the single-stream, in-order valid/result/rtag comparison.

---
 rtl/epw_result_scoreboard_pkg.sv | 23 ++
 rtl/epw_scb_slot.sv | 106 ++++++++++
 rtl/epw_result_scoreboard.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/epw_result_scoreboard_pkg.sv
// Shared types and default sizing for the result scoreboard.
package epw_result_scoreboard_pkg;

  localparam int unsigned RESULT_W_DEF = 32;
  localparam int unsigned TAG_W_DEF    = 4;
  localparam int unsigned TIMEOUT_DEF  = 64;
  localparam int unsigned CNT_W_DEF    = 16;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    REF_HELD = 2'd1,
    DUV_HELD = 2'd2
  } slot_state_e;

  // Record of one tag slot at default sizing
  typedef struct packed {
    slot_state_e                    state;
    logic [RESULT_W_DEF-1:0]        result;
    logic                           error;
    logic [$clog2(TIMEOUT_DEF)-1:0] age;
  } scb_slot_t;

endpackage

// File: rtl/epw_scb_slot.sv
// One tag slot: holds the one-sided completion, its age, and requests expiry.
module epw_scb_slot
  import epw_result_scoreboard_pkg::*;
#(
  parameter int unsigned RESULT_W = RESULT_W_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                ref_hit,
  input  logic                duv_hit,
  input  logic [RESULT_W-1:0] ref_result,
  input  logic                ref_error,
  input  logic [RESULT_W-1:0] duv_result,
  input  logic                duv_error,
  input  logic                expire_grant,
  output slot_state_e         state,
  output logic [RESULT_W-1:0] result,
  output logic                error,
  output logic                expire_req
);

  localparam int unsigned AGE_W = $clog2(TIMEOUT);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT - 1);

  slot_state_e         state_n;
  logic [RESULT_W-1:0] result_n;
  logic                error_n;
  logic [AGE_W-1:0]    age, age_n;

  // Slot state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      result <= '0;
      error  <= 1'b0;
      age    <= '0;
    end else begin
      state  <= state_n;
      result <= result_n;
      error  <= error_n;
      age    <= age_n;
    end
  end

  // Next-state: arrivals take priority over aging/expiry
  always_comb begin
    state_n  = state;
    result_n = result;
    error_n  = error;
    age_n    = age;
    if (enable) begin
      if (ref_hit && duv_hit) begin
        // Both sides on one tag: the held side is consumed by the opposite
        // arrival and the same-side arrival takes its place.
        case (state)
          REF_HELD: begin
            result_n = ref_result;
            error_n  = ref_error;
            age_n    = '0;
          end
          DUV_HELD: begin
            result_n = duv_result;
            error_n  = duv_error;
            age_n    = '0;
          end
          default: ;
        endcase
      end else if (ref_hit) begin
        if (state == DUV_HELD) begin
          state_n = EMPTY;
          age_n   = '0;
        end else begin
          state_n  = REF_HELD;
          result_n = ref_result;
          error_n  = ref_error;
          age_n    = '0;
        end
      end else if (duv_hit) begin
        if (state == REF_HELD) begin
          state_n = EMPTY;
          age_n   = '0;
        end else begin
          state_n  = DUV_HELD;
          result_n = duv_result;
          error_n  = duv_error;
          age_n    = '0;
        end
      end else if (state != EMPTY) begin
        if (expire_grant) begin
          state_n = EMPTY;
          age_n   = '0;
        end else if (age != AGE_MAX) begin
          age_n = age + AGE_W'(1);
        end
      end
    end
  end

  // Expiry request: held, fully aged, enabled and not rescued by an arrival
  always_comb begin
    expire_req = enable && (state != EMPTY) && !ref_hit && !duv_hit && (age == AGE_MAX);
  end

endmodule

// File: rtl/epw_result_scoreboard.sv
// Tag-indexed out-of-order result scoreboard pairing reference and DUV completions.
module epw_result_scoreboard
  import epw_result_scoreboard_pkg::*;
#(
  parameter int unsigned RESULT_W = RESULT_W_DEF,
  parameter int unsigned TAG_W    = TAG_W_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                ref_valid,
  input  logic [TAG_W-1:0]    ref_rtag,
  input  logic [RESULT_W-1:0] ref_result,
  input  logic                ref_error,
  input  logic                duv_valid,
  input  logic [TAG_W-1:0]    duv_rtag,
  input  logic [RESULT_W-1:0] duv_result,
  input  logic                duv_error,
  output logic                mismatch,
  output logic [TAG_W-1:0]    mismatch_tag,
  output logic                timeout,
  output logic [TAG_W-1:0]    timeout_tag,
  output logic                dup,
  output logic [CNT_W-1:0]    pass_cnt,
  output logic [CNT_W-1:0]    fail_cnt,
  output logic [TAG_W:0]      pending,
  output logic                idle
);

  localparam int unsigned DEPTH = 2 ** TAG_W;

  slot_state_e         slot_state  [DEPTH];
  logic [RESULT_W-1:0] slot_result [DEPTH];
  logic                slot_error  [DEPTH];
  logic [DEPTH-1:0]    ref_hit, duv_hit, expire_req, expire_grant;

  logic                ref_fire, duv_fire, same_tag;
  slot_state_e         ref_state, duv_state;
  logic                ref_cmp, duv_cmp, ref_ok, duv_ok;
  logic [RESULT_W-1:0] ref_peer_result;
  logic                ref_peer_error;
  logic                dup_n, expire_any;
  logic [TAG_W-1:0]    expire_tag;
  logic [1:0]          pass_inc, fail_inc;

  function automatic logic cmp_match(input logic ea, input logic [RESULT_W-1:0] ra,
                                     input logic eb, input logic [RESULT_W-1:0] rb);
    return (ea == eb) && (ea || (ra == rb));
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W + 1)'(inc);
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  assign ref_fire = enable && ref_valid;
  assign duv_fire = enable && duv_valid;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign ref_hit[i] = ref_fire && (ref_rtag == TAG_W'(i));
    assign duv_hit[i] = duv_fire && (duv_rtag == TAG_W'(i));

    epw_scb_slot #(
      .RESULT_W (RESULT_W),
      .TIMEOUT  (TIMEOUT)
    ) u_slot (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .ref_hit      (ref_hit[i]),
      .duv_hit      (duv_hit[i]),
      .ref_result   (ref_result),
      .ref_error    (ref_error),
      .duv_result   (duv_result),
      .duv_error    (duv_error),
      .expire_grant (expire_grant[i]),
      .state        (slot_state[i]),
      .result       (slot_result[i]),
      .error        (slot_error[i]),
      .expire_req   (expire_req[i])
    );
  end

  // Compare selection: ref side also owns the direct compare on an empty shared tag
  always_comb begin
    same_tag        = (ref_rtag == duv_rtag);
    ref_state       = slot_state[ref_rtag];
    duv_state       = slot_state[duv_rtag];
    ref_cmp         = ref_fire && ((ref_state == DUV_HELD) ||
                                   (duv_fire && same_tag && (ref_state == EMPTY)));
    ref_peer_result = (ref_state == DUV_HELD) ? slot_result[ref_rtag] : duv_result;
    ref_peer_error  = (ref_state == DUV_HELD) ? slot_error[ref_rtag]  : duv_error;
    ref_ok          = cmp_match(ref_error, ref_result, ref_peer_error, ref_peer_result);
    duv_cmp         = duv_fire && (duv_state == REF_HELD);
    duv_ok          = cmp_match(slot_error[duv_rtag], slot_result[duv_rtag], duv_error, duv_result);
    dup_n           = (ref_fire && (ref_state == REF_HELD) && !(duv_fire && same_tag)) ||
                      (duv_fire && (duv_state == DUV_HELD) && !(ref_fire && same_tag));
  end

  // Lowest-index expiry priority encoder
  always_comb begin
    expire_grant = '0;
    expire_any   = 1'b0;
    expire_tag   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (expire_req[i] && !expire_any) begin
        expire_grant[i] = 1'b1;
        expire_any      = 1'b1;
        expire_tag      = TAG_W'(i);
      end
    end
  end

  // Per-cycle counter increments
  always_comb begin
    pass_inc = {1'b0, ref_cmp && ref_ok} + {1'b0, duv_cmp && duv_ok};
    fail_inc = {1'b0, ref_cmp && !ref_ok} + {1'b0, duv_cmp && !duv_ok} + {1'b0, expire_any};
  end

  // Registered event pulses, tags and saturating counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mismatch     <= 1'b0;
      mismatch_tag <= '0;
      timeout      <= 1'b0;
      timeout_tag  <= '0;
      dup          <= 1'b0;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
    end else begin
      mismatch <= (ref_cmp && !ref_ok) || (duv_cmp && !duv_ok);
      if (ref_cmp && !ref_ok) begin
        mismatch_tag <= ref_rtag;
      end else if (duv_cmp && !duv_ok) begin
        mismatch_tag <= duv_rtag;
      end
      timeout <= expire_any;
      if (expire_any) begin
        timeout_tag <= expire_tag;
      end
      dup      <= dup_n;
      pass_cnt <= sat_add(pass_cnt, pass_inc);
      fail_cnt <= sat_add(fail_cnt, fail_inc);
    end
  end

  // Occupancy popcount over registered slot states
  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (slot_state[i] != EMPTY) begin
        pending = pending + (TAG_W + 1)'(1);
      end
    end
    idle = (pending == '0);
  end

endmodule
